// File: rtl/proc_pkg.sv
// Shared definitions for the simple 16-bit processor control unit and its datapath.
package proc_pkg;

    localparam int unsigned IR_W   = 9;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned REG_N  = 8;
    localparam int unsigned OP_HI  = 8;
    localparam int unsigned OP_LO  = 6;
    localparam int unsigned X_HI   = 5;
    localparam int unsigned X_LO   = 3;
    localparam int unsigned Y_HI   = 2;
    localparam int unsigned Y_LO   = 0;

    typedef enum logic [SEL_W-1:0] {
        OP_MV  = 3'd0,
        OP_MVI = 3'd1,
        OP_ADD = 3'd2,
        OP_SUB = 3'd3
    } opcode_e;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_e;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module dec3to8
    import proc_pkg::*;
(
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [REG_N-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_ctrl.sv
// Control FSM for the 16-bit processor: captures IR from DIN and sequences
// mv/mvi/add/sub over T0..T3, driving bus selects and load enables.
module proc_ctrl
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic              IRin,
    output logic [REG_N-1:0]  Rout,
    output logic              Gout,
    output logic              DINout,
    output logic [REG_N-1:0]  Rin,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
    output logic              Done
);

    state_e             state_q;
    state_e             state_d;
    logic [IR_W-1:0]    ir_q;
    logic               ir_ld;

    logic [SEL_W-1:0]   op;
    logic [SEL_W-1:0]   x_sel;
    logic [SEL_W-1:0]   y_sel;
    logic [REG_N-1:0]   x_oh;
    logic [REG_N-1:0]   y_oh;

    logic               irin_c;
    logic [REG_N-1:0]   rout_c;
    logic               gout_c;
    logic               dinout_c;
    logic [REG_N-1:0]   rin_c;
    logic               ain_c;
    logic               gin_c;
    logic               addsub_c;
    logic               done_c;

    // Only the top IR_W bits of DIN form the instruction word.
    logic               unused_din;
    assign unused_din = ^DIN[DATA_W-IR_W-1:0];

    assign op    = ir_q[OP_HI:OP_LO];
    assign x_sel = ir_q[X_HI:X_LO];
    assign y_sel = ir_q[Y_HI:Y_LO];

    dec3to8 u_dec_x (
        .en  (Resetn),
        .sel (x_sel),
        .y   (x_oh)
    );

    dec3to8 u_dec_y (
        .en  (Resetn),
        .sel (y_sel),
        .y   (y_oh)
    );

    // State and instruction register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ir_ld) begin
                ir_q <= DIN[DATA_W-1 -: IR_W];
            end
        end
    end

    // Next-state and per-step control decode.
    always_comb begin
        state_d  = state_q;
        ir_ld    = 1'b0;
        irin_c   = 1'b0;
        rout_c   = '0;
        gout_c   = 1'b0;
        dinout_c = 1'b0;
        rin_c    = '0;
        ain_c    = 1'b0;
        gin_c    = 1'b0;
        addsub_c = 1'b0;
        done_c   = 1'b0;

        case (state_q)
            T0: begin
                if (Run) begin
                    irin_c  = 1'b1;
                    ir_ld   = 1'b1;
                    state_d = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        rout_c  = y_oh;
                        rin_c   = x_oh;
                        done_c  = 1'b1;
                        state_d = T0;
                    end
                    OP_MVI: begin
                        dinout_c = 1'b1;
                        rin_c    = x_oh;
                        done_c   = 1'b1;
                        state_d  = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_c  = x_oh;
                        ain_c   = 1'b1;
                        state_d = T2;
                    end
                    default: begin
                        done_c  = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T2: begin
                rout_c   = y_oh;
                gin_c    = 1'b1;
                addsub_c = (op == OP_SUB);
                state_d  = T3;
            end
            T3: begin
                gout_c  = 1'b1;
                rin_c   = x_oh;
                done_c  = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

    // Reset forces every control line low without waiting for a clock.
    assign IRin   = Resetn & irin_c;
    assign Rout   = Resetn ? rout_c : '0;
    assign Gout   = Resetn & gout_c;
    assign DINout = Resetn & dinout_c;
    assign Rin    = Resetn ? rin_c : '0;
    assign Ain    = Resetn & ain_c;
    assign Gin    = Resetn & gin_c;
    assign AddSub = Resetn & addsub_c;
    assign Done   = Resetn & done_c;

    a_bus_one_source: assert property (@(posedge Clock) disable iff (!Resetn)
        $onehot0({|Rout, Gout, DINout}));
    a_rout_onehot: assert property (@(posedge Clock) disable iff (!Resetn)
        $onehot0(Rout));
    a_rin_onehot: assert property (@(posedge Clock) disable iff (!Resetn)
        $onehot0(Rin));
    a_done_pulse: assert property (@(posedge Clock) disable iff (!Resetn)
        Done |=> !Done);

endmodule

// File: doc/proc_ctrl.md
Name: proc_ctrl

Overview:
- Control unit for the simple 16-bit processor datapath.
- Captures the instruction word from DIN into an internal IR and sequences the four instructions over time steps T0..T3.
- Drives the bus-mux select lines (Rout, Gout, DINout) plus register-, A-, G- and IR-load enables and the ALU add/sub control.
- Sits directly upstream of the bus multiplexer and register file.

Parameters:
- DATA_W, 16: width of DIN; IR is DIN[DATA_W-1 -: 9].

Ports:
- Clock  input  1  system clock, rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- Run  input  1  start request; sampled only in T0.
- DIN  input  DATA_W  instruction / immediate word.
- IRin  output  1  IR load strobe (informational; IR is internal).
- Rout  output  8  one-hot bus select for R7..R0 (bit i = Ri).
- Gout  output  1  drive G onto bus.
- DINout  output  1  drive DIN onto bus.
- Rin  output  8  one-hot load enable for R7..R0.
- Ain  output  1  load A from bus.
- Gin  output  1  load G from ALU.
- AddSub  output  1  0 = add, 1 = subtract.
- Done  output  1  one-cycle pulse in the final step of an instruction.

Behaviour:
- IR fields:
  - opcode = IR[8:6]: 000 mv, 001 mvi, 010 add, 011 sub, 100..111 nop.
  - X = IR[5:3], destination.
  - Y = IR[2:0], source.
  - Relative to DIN: opcode = DIN[15:13], X = DIN[12:10], Y = DIN[9:7].
- State register T0..T3 and 9-bit IR are reset asynchronously to T0 / 0 while Resetn = 0.
- While Resetn = 0, every output is forced to 0 regardless of Run.
- Outputs are combinational from state, IR and Run (Run only in T0). Unlisted outputs are 0 in each step.
- T0:
  - Run = 1: IRin = 1, IR <= DIN[15:7] at the edge, next T1.
  - Run = 0: stay in T0, IR unchanged.
- T1:
  - mv: Rout[Y] = 1, Rin[X] = 1, Done = 1, next T0.
  - mvi: DINout = 1, Rin[X] = 1, Done = 1, next T0. The immediate must be on DIN during T1.
  - add/sub: Rout[X] = 1, Ain = 1, next T2.
  - nop: Done = 1 only, next T0.
- T2: Rout[Y] = 1, Gin = 1, AddSub = (opcode == 011), next T3.
- T3: Gout = 1, Rin[X] = 1, Done = 1, next T0.
- Latency from the Run-sampled edge to Done:
  - mv, mvi, nop: Done in the cycle after T0.
  - add, sub: Done 3 cycles after T0.
- Invariants checked by assertion:
  - At most one bus source is active per cycle (Rout one-hot or zero; Gout; DINout). The downstream mux applies priority DINout > Gout > Rout, so overlap must never occur.
  - Rin is one-hot or zero.
  - Done is high for exactly one cycle per instruction.
- Run is ignored in T1..T3.
- Run held high continuously starts back-to-back instructions; T0 of the next instruction immediately follows Done.
- mv with X == Y is legal: Rout and Rin both point at the same register.
- Reset mid-instruction: outputs drop to 0 asynchronously, no partial Rin/Gin completes, and the FSM restarts at T0 after release.
- IR changes only on a T0 & Run edge.

Decomposition:
- Shared package proc_pkg:
  - opcode enum (OP_MV, OP_MVI, OP_ADD, OP_SUB).
  - state enum (T0, T1, T2, T3).
  - IR field index constants.
  - Shared with the datapath and bench.
- One sub-module, dec3to8: 3-bit to 8-bit one-hot decoder with enable, instantiated twice (X and Y).

Test Plan:
1. Reset: Resetn = 0 with Run = 1, DIN = 16'h4180 → all outputs 0, IR = 0. Release, Run = 0 → stays T0, outputs 0.
2. mv R2,R5: DIN = 16'h0A80, Run = 1 for one cycle.
   - T0: IRin = 1.
   - Next cycle: Rout = 8'h20, Rin = 8'h04, Done = 1.
   - Following cycle: back in T0.
3. mvi R1,#0x1234: DIN = 16'h2400 in T0, then 16'h1234 in T1.
   - T1: DINout = 1, Rin = 8'h02, Done = 1, Rout = 0.
4. add R0,R3: DIN = 16'h4180.
   - T1: Rout = 8'h01, Ain = 1.
   - T2: Rout = 8'h08, Gin = 1, AddSub = 0.
   - T3: Gout = 1, Rin = 8'h01, Done = 1.
5. sub R7,R6: DIN = 16'h7F00.
   - T2: Rout = 8'h40, AddSub = 1.
   - T3: Rin = 8'h80, Done = 1.
   - Run held high through T1..T3 → no restart until T0, then a new IRin.
6. Reset and nop:
   - Resetn pulsed low during T2 of add → outputs 0 immediately; after release, mv DIN = 16'h0A80 executes exactly as in test 2.
   - Opcode 100 (DIN = 16'h8000) → T1 Done = 1 only, Rin = 0.
